// File: rtl/snn_pkg.sv
// snn_pkg
// Shared definitions for the spiking-network datapath: the LIF layer state
// encoding and the default geometry constants. The MVM accelerator also
// imports this package, so its row count and result width must stay in
// step with the LIF layer defaults below.
// No ports (package).
package snn_pkg;

    // Phases of the LIF layer: gather one row result per neuron, sweep
    // the neurons through the shared update unit, then hold the spikes
    // until the consumer takes them.
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        UPDATE  = 2'd1,
        PRESENT = 2'd2
    } lif_state_t;

    localparam int DEF_NEURONS    = 4;
    localparam int DEF_VWIDTH     = 10;
    localparam int DEF_THRESHOLD  = 128;
    localparam int DEF_LEAK_SHIFT = 3;

    // Geometry of the upstream MVM accelerator.
    localparam int MVM_ROWS    = 4;
    localparam int MVM_VALUE_W = 8;

endpackage

// File: rtl/lif_update.sv
// lif_update
// Combinational leaky integrate-and-fire step for a single neuron. The top
// level owns one copy and time-multiplexes it over all neurons.
//
// Ports:
//   v         - current membrane potential (unsigned, VWIDTH bits)
//   in_val    - 8-bit synaptic input for this timestep
//   threshold - firing threshold
//   v_next    - membrane potential to store back
//   spike     - neuron fires this timestep
//
// Configuration macro: LIF_SOFT_RESET_EN
//   defined   -> after a spike the membrane keeps the residue above threshold
//   undefined -> after a spike the membrane is forced to zero
module lif_update
    import snn_pkg::*;
#(
    parameter int VWIDTH     = DEF_VWIDTH,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
    input  logic [VWIDTH-1:0] v,
    input  logic [7:0]        in_val,
    input  logic [VWIDTH-1:0] threshold,
    output logic [VWIDTH-1:0] v_next,
    output logic              spike
);

    localparam logic [VWIDTH:0] VMAX = {1'b0, {VWIDTH{1'b1}}};

    logic [VWIDTH-1:0] leaked;
    logic [VWIDTH:0]   sum;
    logic [VWIDTH-1:0] vn;

    // Leak first (a shift of zero drains the whole membrane), then add the
    // input one bit wider than the membrane so the saturation test can see
    // the carry, clamp, and compare against the threshold.
    always_comb begin
        leaked = v - (v >> LEAK_SHIFT);
        sum    = {1'b0, leaked} + {{(VWIDTH + 1 - 8){1'b0}}, in_val};
        vn     = (sum > VMAX) ? {VWIDTH{1'b1}} : sum[VWIDTH-1:0];
        spike  = (vn >= threshold);
`ifdef LIF_SOFT_RESET_EN
        v_next = spike ? (vn - threshold) : vn;
`else
        v_next = spike ? '0 : vn;
`endif
    end

endmodule

// File: rtl/lif_spike_layer.sv
// lif_spike_layer
// Integrates the per-row 8-bit results of the sparse MVM accelerator into
// leaky integrate-and-fire membranes (one neuron per matrix row) and
// presents one spike vector per timestep.
//
// Ports:
//   clk, rst_n   - clock and asynchronous active-low reset
//   output_val   - MVM row result, valid on each level change of sending_out
//   sending_out  - MVM toggle strobe (must reset to 0 along with this block)
//   clear        - synchronous clear of membranes, buffer and collection
//   spike_ready  - consumer accepts spike_train
//   spike_train  - spikes of the last timestep (kept after acceptance)
//   spike_valid  - spike_train is new and not yet accepted
//   timestep     - number of accepted timesteps, wraps at 255
//   overflow     - sticky: a strobe arrived while not collecting
//
// Configuration macro: LIF_SOFT_RESET_EN (soft membrane reset on spike,
// implemented inside lif_update).
module lif_spike_layer
    import snn_pkg::*;
#(
    parameter int NEURONS    = DEF_NEURONS,
    parameter int VWIDTH     = DEF_VWIDTH,
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         output_val,
    input  logic               sending_out,
    input  logic               clear,
    input  logic               spike_ready,
    output logic [NEURONS-1:0] spike_train,
    output logic               spike_valid,
    output logic [7:0]         timestep,
    output logic               overflow
);

    localparam int              IDXW = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NEURONS - 1);
    localparam logic [VWIDTH-1:0] THR = VWIDTH'(THRESHOLD);

    lif_state_t state;
    lif_state_t state_next;

    logic               tog_q;
    logic               stb;
    logic [IDXW-1:0]    idx;
    logic [IDXW-1:0]    k;
    logic [7:0]         in_buf [NEURONS];
    logic [VWIDTH-1:0]  v_mem  [NEURONS];
    logic [NEURONS-1:0] spk;
    logic [NEURONS-1:0] spk_now;
    logic [VWIDTH-1:0]  v_next;
    logic               fire;

    // Every level change of sending_out is one delivered row; the value is
    // taken on the same edge the change is seen.
    assign stb = sending_out ^ tog_q;

    lif_update #(
        .VWIDTH     (VWIDTH),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_update (
        .v         (v_mem[k]),
        .in_val    (in_buf[k]),
        .threshold (THR),
        .v_next    (v_next),
        .spike     (fire)
    );

    // The spike vector including the neuron being updated this cycle, so
    // the last neuron's result reaches spike_train on the same edge.
    always_comb begin
        spk_now    = spk;
        spk_now[k] = fire;
    end

    // Phase sequencing: leave COLLECT on the capture of the last row, sweep
    // every neuron once in UPDATE, and wait in PRESENT for the handshake.
    // clear always returns to COLLECT.
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (stb && idx == LAST) state_next = UPDATE;
            UPDATE:  if (k == LAST)          state_next = PRESENT;
            PRESENT: if (spike_ready)        state_next = COLLECT;
            default:                         state_next = COLLECT;
        endcase
        if (clear) state_next = COLLECT;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_next;
    end

    // Datapath: row capture, time-multiplexed membrane update, spike
    // presentation and the sticky overflow flag. A strobe that arrives
    // outside COLLECT, including on the accepting edge, is dropped so the
    // next timestep always starts at row 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tog_q       <= 1'b0;
            idx         <= '0;
            k           <= '0;
            spk         <= '0;
            spike_train <= '0;
            spike_valid <= 1'b0;
            timestep    <= '0;
            overflow    <= 1'b0;
            for (int i = 0; i < NEURONS; i++) begin
                in_buf[i] <= '0;
                v_mem[i]  <= '0;
            end
        end else if (clear) begin
            tog_q       <= sending_out;
            idx         <= '0;
            k           <= '0;
            spike_valid <= 1'b0;
            overflow    <= 1'b0;
            for (int i = 0; i < NEURONS; i++) begin
                in_buf[i] <= '0;
                v_mem[i]  <= '0;
            end
        end else begin
            tog_q <= sending_out;
            if (stb && state != COLLECT) overflow <= 1'b1;
            case (state)
                COLLECT: begin
                    if (stb) begin
                        in_buf[idx] <= output_val;
                        if (idx == LAST) begin
                            idx <= '0;
                            k   <= '0;
                        end else begin
                            idx <= idx + IDXW'(1);
                        end
                    end
                end
                UPDATE: begin
                    v_mem[k] <= v_next;
                    spk      <= spk_now;
                    if (k == LAST) begin
                        k           <= '0;
                        spike_train <= spk_now;
                        spike_valid <= 1'b1;
                    end else begin
                        k <= k + IDXW'(1);
                    end
                end
                PRESENT: begin
                    if (spike_ready) begin
                        spike_valid <= 1'b0;
                        timestep    <= timestep + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lif_spike_layer.sv
// tb_lif_spike_layer
// Bench for lif_spike_layer. dut_a uses the default parameters; dut_b raises
// THRESHOLD to 1023 to exercise membrane saturation. Each issued timestep
// pushes its expected spike vector and timestep into a per-DUT queue; a
// monitor per DUT pops and compares whenever spike_valid appears.
module tb_lif_spike_layer;

    typedef struct {
        logic [3:0] spikes;
        logic [7:0] ts;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a_val, b_val;
    logic       a_send, b_send, a_clear, b_clear, a_ready, b_ready;
    logic [3:0] a_spk, b_spk;
    logic       a_valid, b_valid;
    logic [7:0] a_ts, b_ts;
    logic       a_ovf, b_ovf;

    int   checks = 0;
    int   passes = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    bit   seen_a, seen_b;
    exp_t e_a, e_b;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    lif_spike_layer #(
        .NEURONS(4), .VWIDTH(10), .THRESHOLD(128), .LEAK_SHIFT(3)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .output_val(a_val), .sending_out(a_send),
        .clear(a_clear), .spike_ready(a_ready), .spike_train(a_spk),
        .spike_valid(a_valid), .timestep(a_ts), .overflow(a_ovf)
    );

    lif_spike_layer #(
        .NEURONS(4), .VWIDTH(10), .THRESHOLD(1023), .LEAK_SHIFT(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .output_val(b_val), .sending_out(b_send),
        .clear(b_clear), .spike_ready(b_ready), .spike_train(b_spk),
        .spike_valid(b_valid), .timestep(b_ts), .overflow(b_ovf)
    );

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual == required) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    endtask

    // Monitor for dut_a: compare once per rising spike_valid.
    initial begin
        seen_a = 1'b0;
        forever begin
            @(negedge clk);
            if (a_valid && !seen_a) begin
                seen_a = 1'b1;
                if (q_a.size() == 0) begin
                    checkOutput("a unexpected spike_valid", 1, 0);
                end else begin
                    e_a = q_a.pop_front();
                    checkOutput("a spike_train", int'(a_spk), int'(e_a.spikes));
                    checkOutput("a timestep", int'(a_ts), int'(e_a.ts));
                end
            end else if (!a_valid) begin
                seen_a = 1'b0;
            end
        end
    end

    // Monitor for dut_b.
    initial begin
        seen_b = 1'b0;
        forever begin
            @(negedge clk);
            if (b_valid && !seen_b) begin
                seen_b = 1'b1;
                if (q_b.size() == 0) begin
                    checkOutput("b unexpected spike_valid", 1, 0);
                end else begin
                    e_b = q_b.pop_front();
                    checkOutput("b spike_train", int'(b_spk), int'(e_b.spikes));
                    checkOutput("b timestep", int'(b_ts), int'(e_b.ts));
                end
            end else if (!b_valid) begin
                seen_b = 1'b0;
            end
        end
    end

    function automatic logic validOf(input int sel);
        return (sel == 0) ? a_valid : b_valid;
    endfunction

    // One toggle of sending_out with a value; returns on the capturing edge.
    task automatic deliver(input int sel, input logic [7:0] v);
        @(negedge clk);
        if (sel == 0) begin a_val = v; a_send = ~a_send; end
        else          begin b_val = v; b_send = ~b_send; end
        @(posedge clk);
    endtask

    // Count edges from the last capture to spike_valid (expect 4).
    task automatic waitValid(input int sel);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!validOf(sel) && n < 20);
        checkOutput(sel == 0 ? "a valid latency" : "b valid latency",
                    validOf(sel) ? n : -1, 4);
    endtask

    task automatic applyStimulus(input int sel, input logic [7:0] v0, input logic [7:0] v1,
                                 input logic [7:0] v2, input logic [7:0] v3,
                                 input logic [3:0] exp_spk, input logic [7:0] exp_ts);
        exp_t e;
        e.spikes = exp_spk;
        e.ts     = exp_ts;
        if (sel == 0) q_a.push_back(e);
        else          q_b.push_back(e);
        deliver(sel, v0);
        deliver(sel, v1);
        deliver(sel, v2);
        deliver(sel, v3);
        waitValid(sel);
    endtask

    task automatic acceptStep(input int sel);
        @(negedge clk);
        if (sel == 0) a_ready = 1'b1; else b_ready = 1'b1;
        @(posedge clk);
        #1;
        if (sel == 0) a_ready = 1'b0; else b_ready = 1'b0;
        checkOutput(sel == 0 ? "a valid after accept" : "b valid after accept",
                    int'(validOf(sel)), 0);
    endtask

    // Overall time bound.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Hand-computed V0 trajectory for dut_b with 255 on every row.
    int b_v0 [6] = '{255, 479, 675, 846, 996, 0};

    initial begin
        rst_n = 1'b0;
        a_val = '0; b_val = '0; a_send = 1'b0; b_send = 1'b0;
        a_clear = 1'b0; b_clear = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset spike_train", int'(a_spk), 0);
        checkOutput("reset spike_valid", int'(a_valid), 0);
        checkOutput("reset timestep", int'(a_ts), 0);
        checkOutput("reset overflow", int'(a_ovf), 0);
        rst_n = 1'b1;

        // Basic firing: 200 and 128 fire, 127 is kept.
        applyStimulus(0, 8'd200, 8'd0, 8'd127, 8'd128, 4'b1001, 8'd0);
        checkOutput("a V2 after step0", int'(dut_a.v_mem[2]), 127);
        checkOutput("a V0 after spike", int'(dut_a.v_mem[0]), 0);
        acceptStep(0);

        // 127 - 15 + 20 = 132 crosses the threshold.
        applyStimulus(0, 8'd0, 8'd0, 8'd20, 8'd0, 4'b0100, 8'd1);
        checkOutput("a V2 after step1", int'(dut_a.v_mem[2]), 0);
        acceptStep(0);

        // Preload V0 = 100, then leak 100 -> 88 -> 77.
        applyStimulus(0, 8'd100, 8'd0, 8'd0, 8'd0, 4'b0000, 8'd2);
        checkOutput("a V0 preload", int'(dut_a.v_mem[0]), 100);
        acceptStep(0);
        applyStimulus(0, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000, 8'd3);
        checkOutput("a V0 leak1", int'(dut_a.v_mem[0]), 88);
        acceptStep(0);
        applyStimulus(0, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000, 8'd4);
        checkOutput("a V0 leak2", int'(dut_a.v_mem[0]), 77);

        // Strobe while presenting: dropped and flagged.
        deliver(0, 8'd55);
        #1;
        checkOutput("a overflow set", int'(a_ovf), 1);
        checkOutput("a valid held", int'(a_valid), 1);
        acceptStep(0);
        applyStimulus(0, 8'd1, 8'd2, 8'd3, 8'd4, 4'b0000, 8'd5);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("a buf%0d", i), int'(dut_a.in_buf[i]), i + 1);
        checkOutput("a overflow sticky", int'(a_ovf), 1);
        checkOutput("a V0 step5", int'(dut_a.v_mem[0]), 69);
        acceptStep(0);

        // clear: membranes and overflow drop, timestep kept.
        @(negedge clk);
        a_clear = 1'b1;
        @(posedge clk);
        #1;
        a_clear = 1'b0;
        checkOutput("a overflow cleared", int'(a_ovf), 0);
        checkOutput("a timestep kept", int'(a_ts), 6);
        checkOutput("a V0 cleared", int'(dut_a.v_mem[0]), 0);
        applyStimulus(0, 8'd120, 8'd126, 8'd125, 8'd0, 4'b0000, 8'd6);
        acceptStep(0);

        // Strobe on the accepting edge is dropped; next step starts at row 0.
        applyStimulus(0, 8'd0, 8'd0, 8'd0, 8'd130, 4'b1000, 8'd7);
        @(negedge clk);
        a_ready = 1'b1;
        a_val   = 8'd99;
        a_send  = ~a_send;
        @(posedge clk);
        #1;
        a_ready = 1'b0;
        checkOutput("a same-edge valid", int'(a_valid), 0);
        checkOutput("a same-edge overflow", int'(a_ovf), 1);
        checkOutput("a same-edge timestep", int'(a_ts), 8);
        applyStimulus(0, 8'd130, 8'd0, 8'd0, 8'd0, 4'b0001, 8'd8);
        acceptStep(0);

        // Asynchronous reset in the middle of the update sweep (k = 2).
        deliver(0, 8'd200);
        deliver(0, 8'd200);
        deliver(0, 8'd200);
        deliver(0, 8'd200);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        a_send = 1'b0;
        #1;
        checkOutput("async reset spike_train", int'(a_spk), 0);
        checkOutput("async reset spike_valid", int'(a_valid), 0);
        checkOutput("async reset timestep", int'(a_ts), 0);
        checkOutput("async reset overflow", int'(a_ovf), 0);
        checkOutput("async reset V0", int'(dut_a.v_mem[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 8'd200, 8'd0, 8'd127, 8'd128, 4'b1001, 8'd0);
        checkOutput("a V2 after reset", int'(dut_a.v_mem[2]), 127);
        acceptStep(0);

        // Saturation on dut_b: V0 clamps at 1023 on the sixth step.
        for (int s = 0; s < 6; s++) begin
            applyStimulus(1, 8'd255, 8'd255, 8'd255, 8'd255,
                          (s == 5) ? 4'b1111 : 4'b0000, 8'(s));
            checkOutput($sformatf("b V0 step%0d", s), int'(dut_b.v_mem[0]), b_v0[s]);
            acceptStep(1);
        end

        repeat (4) @(posedge clk);
        checkOutput("a queue drained", q_a.size(), 0);
        checkOutput("b queue drained", q_b.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
